// File: rtl/piece_queue.sv
// Piece queue: samples the random piece selector into a DEPTH-entry shift queue with
// an anti-repeat rule, and hands the head piece to the game FSM via valid/request.
module piece_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 4
) (
  input  logic          clka,
  input  logic          restart,
  input  logic [1:0]    random,
  input  logic          start,
  input  logic          game_over,
  input  logic          spawn_req,
  output logic          spawn_valid,
  output logic [1:0]    spawn_piece,
  output logic [1:0]    next_piece,
  output logic [CW-1:0] count,
  output logic [7:0]    issued,
  output logic          busy
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFill  = 2'd1;
  localparam logic [1:0] StReady = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    r_queue [DEPTH];
  logic [CW-1:0] r_count;
  logic [7:0]    r_issued;
  logic [1:0]    r_last;
  logic          r_last_valid;

  logic [1:0]    w_state_d;
  logic [1:0]    w_queue_d [DEPTH];
  logic [CW-1:0] w_count_d;
  logic [7:0]    w_issued_d;
  logic [1:0]    w_last_d;
  logic          w_last_valid_d;
  logic [1:0]    w_push;

  // Anti-repeat: bump the sample by one when it would duplicate the previous push.
  assign w_push = (r_last_valid && (random == r_last)) ? random + 2'd1 : random;

  always_comb begin
    w_state_d      = r_state;
    w_queue_d      = r_queue;
    w_count_d      = r_count;
    w_issued_d     = r_issued;
    w_last_d       = r_last;
    w_last_valid_d = r_last_valid;

    if (game_over) begin
      // issued is held so the score survives the end of the game
      w_state_d      = StIdle;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        w_queue_d[i] = 2'd0;
      end
      w_count_d      = '0;
      w_last_valid_d = 1'b0;
    end else if (start) begin
      w_state_d      = StFill;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        w_queue_d[i] = 2'd0;
      end
      w_count_d      = '0;
      w_issued_d     = '0;
      w_last_valid_d = 1'b0;
    end else begin
      case (r_state)
        StFill: begin
          for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CW'(i) == r_count) begin
              w_queue_d[i] = w_push;
            end
          end
          w_count_d      = r_count + 1'b1;
          w_last_d       = w_push;
          w_last_valid_d = 1'b1;
          if (r_count == CW'(DEPTH - 1)) begin
            w_state_d = StReady;
          end
        end
        StReady: begin
          if (spawn_req) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
              w_queue_d[i] = r_queue[i+1];
            end
            w_queue_d[DEPTH-1] = w_push;
            w_issued_d         = r_issued + 8'd1;
            w_last_d           = w_push;
            w_last_valid_d     = 1'b1;
          end
        end
        StIdle: begin
          w_state_d = StIdle;
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      r_state      <= StIdle;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_queue[i] <= 2'd0;
      end
      r_count      <= '0;
      r_issued     <= '0;
      r_last       <= 2'd0;
      r_last_valid <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_queue[i] <= w_queue_d[i];
      end
      r_count      <= w_count_d;
      r_issued     <= w_issued_d;
      r_last       <= w_last_d;
      r_last_valid <= w_last_valid_d;
    end
  end

  assign spawn_valid = (r_state == StReady);
  assign busy        = (r_state == StFill);
  assign spawn_piece = r_queue[0];
  assign next_piece  = r_queue[1];
  assign count       = r_count;
  assign issued      = r_issued;

endmodule

// File: tb/tb_piece_queue.sv
// Directed bench for piece_queue: a reference queue acts as scoreboard, filled as pieces
// are sampled and popped as the DUT hands pieces out.
module tb_piece_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 4;

  localparam int MIdle  = 0;
  localparam int MFill  = 1;
  localparam int MReady = 2;

  logic          clka;
  logic          restart;
  logic [1:0]    random;
  logic          start;
  logic          game_over;
  logic          spawn_req;
  logic          spawn_valid;
  logic [1:0]    spawn_piece;
  logic [1:0]    next_piece;
  logic [CW-1:0] count;
  logic [7:0]    issued;
  logic          busy;

  int n_cmp;
  int n_err;

  // reference model state
  logic [1:0] m_q [$];
  logic [1:0] m_last;
  logic       m_lv;
  logic [7:0] m_issued;
  int         m_st;

  piece_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clka        (clka),
    .restart     (restart),
    .random      (random),
    .start       (start),
    .game_over   (game_over),
    .spawn_req   (spawn_req),
    .spawn_valid (spawn_valid),
    .spawn_piece (spawn_piece),
    .next_piece  (next_piece),
    .count       (count),
    .issued      (issued),
    .busy        (busy)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_last   = 2'd0;
    m_lv     = 1'b0;
    m_issued = 8'd0;
    m_st     = MIdle;
  endtask

  task automatic model_push();
    logic [1:0] p;
    p = random;
    if (m_lv && p == m_last) p = p + 2'd1;
    m_q.push_back(p);
    m_last = p;
    m_lv   = 1'b1;
  endtask

  // Apply the current inputs to the model, then advance the DUT one edge.
  task automatic step();
    if (game_over) begin
      m_st = MIdle;
      m_q.delete();
      m_lv = 1'b0;
    end else if (start) begin
      m_st = MFill;
      m_q.delete();
      m_lv = 1'b0;
      m_issued = 8'd0;
    end else if (m_st == MFill) begin
      model_push();
      if (m_q.size() == DEPTH) m_st = MReady;
    end else if (m_st == MReady && spawn_req) begin
      void'(m_q.pop_front());
      model_push();
      m_issued = m_issued + 8'd1;
    end
    @(posedge clka);
    #1;
  endtask

  task automatic chk_all(input string tag);
    logic [1:0] e_head;
    logic [1:0] e_next;
    e_head = (m_q.size() > 0) ? m_q[0] : 2'd0;
    e_next = (m_q.size() > 1) ? m_q[1] : 2'd0;
    chk({tag, ".valid"}, 32'(spawn_valid), 32'(m_st == MReady));
    chk({tag, ".busy"},  32'(busy),        32'(m_st == MFill));
    chk({tag, ".count"}, 32'(count),       32'(m_q.size()));
    chk({tag, ".issued"}, 32'(issued),     32'(m_issued));
    chk({tag, ".head"},  32'(spawn_piece), 32'(e_head));
    chk({tag, ".next"},  32'(next_piece),  32'(e_next));
  endtask

  task automatic fill(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_all({tag, ".start"});
    for (int k = 1; k <= DEPTH; k++) begin
      step();
      chk_all($sformatf("%s.push%0d", tag, k));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    restart   = 1'b1;
    random    = 2'd0;
    start     = 1'b0;
    game_over = 1'b0;
    spawn_req = 1'b0;
    model_reset();
    #1;
    chk_all("rst_async");
    repeat (3) @(posedge clka);
    #1;
    restart = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk_all("idle");

    // Fill with constant random=2: 2,3,2,3
    random = 2'd2;
    fill("fill2");
    chk("fill2.head_const", 32'(spawn_piece), 32'd2);
    chk("fill2.next_const", 32'(next_piece), 32'd3);
    chk("fill2.count_const", 32'(count), 32'd4);
    chk("fill2.valid_const", 32'(spawn_valid), 32'd1);

    // Single transfers
    spawn_req = 1'b1;
    step();
    spawn_req = 1'b0;
    chk_all("xfer1");
    chk("xfer1.head_const", 32'(spawn_piece), 32'd3);
    chk("xfer1.next_const", 32'(next_piece), 32'd2);
    chk("xfer1.issued_const", 32'(issued), 32'd1);
    step();
    chk_all("xfer1.idlecyc");
    spawn_req = 1'b1;
    step();
    spawn_req = 1'b0;
    chk_all("xfer2");
    chk("xfer2.head_const", 32'(spawn_piece), 32'd2);
    chk("xfer2.next_const", 32'(next_piece), 32'd3);

    // Back-to-back from a fresh game: 300 transfers wrap issued to 44
    fill("refill");
    spawn_req = 1'b1;
    for (int k = 0; k < 300; k++) begin
      random = 2'(k % 4);
      step();
      chk_all($sformatf("b2b%0d", k));
      n_cmp++;
      assert (spawn_piece !== next_piece) else begin
        n_err++;
        $error("FAIL b2b%0d.adjacent: observed head %0d next %0d, required different",
               k, spawn_piece, next_piece);
      end
    end
    spawn_req = 1'b0;
    chk("b2b.issued_wrap", 32'(issued), 32'd44);

    // start + spawn_req in READY: flush, no transfer counted
    start = 1'b1;
    spawn_req = 1'b1;
    step();
    start = 1'b0;
    spawn_req = 1'b0;
    chk_all("start_req");
    chk("start_req.issued_const", 32'(issued), 32'd0);
    random = 2'd1;
    for (int k = 1; k <= DEPTH; k++) begin
      step();
      chk_all($sformatf("start_req.push%0d", k));
    end
    spawn_req = 1'b1;
    random = 2'd0;
    step();
    chk_all("pre_go.xfer");

    // game_over + spawn_req: back to IDLE, issued held
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    spawn_req = 1'b0;
    chk_all("game_over");
    chk("game_over.valid_const", 32'(spawn_valid), 32'd0);
    chk("game_over.issued_const", 32'(issued), 32'd1);
    step();
    chk_all("game_over.idle");

    // Async reset between edges after the 2nd FILL push
    random = 2'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk_all("midfill");
    #2;
    restart = 1'b1;
    #1;
    model_reset();
    chk_all("midfill.async_rst");
    #2;
    restart = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_all($sformatf("post_rst%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
